// File: rtl/cmos_upload.sv
// rtl/cmos_upload.sv - serves the nibble-wide CMOS RAM to the HPS as packed bytes during an upload session
module cmos_upload #(
    parameter logic [7:0] INDEX = 8'd3,
    parameter int         BYTES = 128
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic [7:0]  ram_addr,
    input  logic [3:0]  ram_q,
    output logic        cpu_hold
);

    typedef enum logic [1:0] {IDLE, ISSUE_HI, CAP_LO, CAP_HI} state_t;

    state_t     state_q;
    logic [7:0] din_q;
    logic       wait_q;
    logic [7:0] ram_addr_q;
    logic [3:0] lo_q;
    logic       hold_q;
    logic       selected;
    logic       in_range;

    assign selected = ioctl_upload && (ioctl_index == INDEX);
    assign in_range = ioctl_addr < 25'(BYTES);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            din_q      <= 8'h00;
            wait_q     <= 1'b0;
            ram_addr_q <= 8'h00;
            lo_q       <= 4'h0;
            hold_q     <= 1'b0;
        end else begin
            hold_q <= selected;
            if (state_q != IDLE && !selected) begin
                // Session dropped mid-transfer: release the HPS, keep the last byte.
                state_q <= IDLE;
                wait_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (selected && ioctl_rd) begin
                            if (in_range) begin
                                ram_addr_q <= {ioctl_addr[6:0], 1'b0};
                                wait_q     <= 1'b1;
                                state_q    <= ISSUE_HI;
                            end else begin
                                din_q <= 8'hFF;
                            end
                        end
                    end
                    ISSUE_HI: begin
                        // Derived from the latched address so a moving ioctl_addr cannot tear the byte.
                        ram_addr_q <= {ram_addr_q[7:1], 1'b1};
                        state_q    <= CAP_LO;
                    end
                    CAP_LO: begin
                        lo_q    <= ram_q;
                        state_q <= CAP_HI;
                    end
                    CAP_HI: begin
                        din_q   <= {ram_q, lo_q};
                        wait_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign ram_addr   = ram_addr_q;
    assign cpu_hold   = hold_q;

endmodule

// File: doc/cmos_upload.md
CMOS_UPLOAD -- requirements
Module: cmos_upload

Interface
REQ-001: Parameter INDEX, default 8'd3: ioctl_index value that selects the CMOS (high-score NVRAM) upload.
REQ-002: Parameter BYTES, default 128: number of packed bytes in the image (2*BYTES nibbles in RAM).
REQ-003: clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-004: reset  in  1  synchronous, active-high reset.
REQ-005: ioctl_upload  in  1  HPS upload session active.
REQ-006: ioctl_index  in  8  session index.
REQ-007: ioctl_rd  in  1  one-cycle byte read request from HPS.
REQ-008: ioctl_addr  in  25  byte address of the request.
REQ-009: ioctl_din  out  8  byte returned to HPS.
REQ-010: ioctl_wait  out  1  HPS must stall while high.
REQ-011: ram_addr  out  8  nibble address to the CMOS RAM read port.
REQ-012: ram_q  in  4  CMOS RAM read data, synchronous, one-cycle latency.
REQ-013: cpu_hold  out  1  freezes game CMOS writes while a matching upload session is active.

Function
REQ-014: The block shall be "selected" when ioctl_upload=1 and ioctl_index=INDEX; otherwise ioctl_rd shall be ignored.
REQ-015: Byte n of the image shall be {nibble[2n+1], nibble[2n]}, with the high nibble from the odd RAM address.
REQ-016: The FSM states shall be IDLE, ISSUE_HI, CAP_LO, CAP_HI.
REQ-017: In IDLE with selected and ioctl_rd=1 and ioctl_addr<BYTES, on edge E0: ram_addr<={addr[6:0],0}, ioctl_wait<=1, state<=ISSUE_HI.
REQ-018: At E1, in ISSUE_HI: ram_addr<={addr[6:0],1}, state<=CAP_LO.
REQ-019: At E2, in CAP_LO: the low nibble shall be latched from ram_q, and state<=CAP_HI.
REQ-020: At E3, in CAP_HI: ioctl_din<={ram_q, low nibble}, ioctl_wait<=0, state<=IDLE.
REQ-021: The request-to-data latency shall be exactly 3 cycles, with ioctl_wait high for exactly 3 cycles.
REQ-022: In IDLE with selected, ioctl_rd=1 and ioctl_addr>=BYTES, ioctl_din shall become 8'hFF at E0, ioctl_wait shall stay 0, and no RAM access shall be made.
REQ-023: ioctl_rd arriving while not in IDLE shall be ignored; no queueing.
REQ-024: If selected drops while not in IDLE, the next edge shall force IDLE and ioctl_wait=0, and ioctl_din shall be left unchanged.
REQ-025: cpu_hold shall be registered selected: it rises one cycle after selection and falls one cycle after deselection.
REQ-026: ram_addr shall hold its last value while in IDLE.
REQ-027: Address comparison shall use all 25 bits, so ioctl_addr=25'h1000000 counts as out of range.

Reset
REQ-028: reset=1 at an edge shall force state=IDLE, ioctl_wait=0, ioctl_din=8'h00, ram_addr=8'h00, cpu_hold=0 and the low-nibble latch=0, overriding any transfer in progress.
REQ-029: After reset deasserts, the first ioctl_rd shall be honoured on the first edge at which it is sampled.

Verification
REQ-030: RAM nibble[0]=4'h5, nibble[1]=4'hA; upload index 3, rd addr 0 -> wait high for 3 cycles, then ioctl_din=8'hA5.
REQ-031: Read addr 127 with nibble[254]=4'h1 and nibble[255]=4'hF -> ioctl_din=8'hF1, ram_addr sequence FE then FF.
REQ-032: Read addr 128 -> ioctl_din=8'hFF on the next edge; wait stays 0; ram_addr unchanged.
REQ-033: ioctl_index=2, rd addr 0 -> no response, wait=0, cpu_hold=0.
REQ-034: Assert reset in CAP_LO -> next edge wait=0, din=00, state=IDLE; a new rd then completes normally.
REQ-035: Drop ioctl_upload in ISSUE_HI -> wait=0 the next edge, din keeps its prior value, cpu_hold falls one cycle later.
